// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a 32-bit word memory, with independent read and write burst engines.
// Optional out-of-range decoding (DECERR) is enabled by defining AXI_MEM_BOUNDS_CHECK_EN.
module axi_mem_slave #(
  parameter int                 DEPTH     = 1024,
  parameter int                 ADDR_W    = 32,
  parameter int                 ID_W      = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int         IDX_W       = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [31:0] mem [DEPTH];

  // Word index aliases modulo DEPTH; the byte offset bits are dropped.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

`ifdef AXI_MEM_BOUNDS_CHECK_EN
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> (IDX_W + 2)) == '0);
  endfunction
`endif

  // ---------------- write channel ----------------
  w_state_t          w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [ID_W-1:0]   w_id;
  logic [7:0]        w_len;
  logic              w_fixed;
  logic [8:0]        w_cnt;
  logic              w_dec;
  logic              w_fire, w_in_len, w_ok, w_we;

  assign w_fire   = s_axi_wvalid & s_axi_wready;
  assign w_in_len = (w_cnt <= {1'b0, w_len});
`ifdef AXI_MEM_BOUNDS_CHECK_EN
  assign w_ok     = in_range(w_addr);
`else
  assign w_ok     = 1'b1;
`endif
  assign w_we     = w_fire & w_in_len & w_ok;

  // NOTE: the memory array has no reset branch; clearing it would force flops instead of RAM.
  always_ff @(posedge s_axi_aclk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: state and registered outputs use <= so every process sees pre-edge values.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_addr        <= '0;
      w_id          <= '0;
      w_len         <= '0;
      w_fixed       <= 1'b0;
      w_cnt         <= '0;
      w_dec         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi_awvalid) begin
          w_id          <= s_axi_awid;
          w_addr        <= s_axi_awaddr;
          w_len         <= s_axi_awlen;
          w_fixed       <= (s_axi_awburst == 2'b00);
          w_cnt         <= '0;
          w_dec         <= 1'b0;
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
          w_state       <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          if (!w_fixed)        w_addr <= w_addr + ADDR_W'(4);
          if (w_cnt != '1)     w_cnt  <= w_cnt + 9'd1;
          if (w_in_len && !w_ok) w_dec <= 1'b1;
          if (s_axi_wlast) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bid    <= w_id;
            // Length mismatch outranks a decode error.
            if (w_cnt != {1'b0, w_len})          s_axi_bresp <= RESP_SLVERR;
            else if (w_dec || (w_in_len && !w_ok)) s_axi_bresp <= RESP_DECERR;
            else                                   s_axi_bresp <= RESP_OKAY;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          w_state       <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic              r_fixed;
  logic [8:0]        r_cnt;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [31:0]       r_fetch_data;
  logic [1:0]        r_fetch_resp;

  // Address of the beat to present next: the AR address when idle, else the following beat.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    r_fetch_addr = s_axi_araddr;
    if (r_state == R_DATA) r_fetch_addr = r_fixed ? r_addr : r_addr + ADDR_W'(4);
    r_fetch_data = mem[word_idx(r_fetch_addr)];
    r_fetch_resp = RESP_OKAY;
`ifdef AXI_MEM_BOUNDS_CHECK_EN
    if (!in_range(r_fetch_addr)) begin
      r_fetch_data = '0;
      r_fetch_resp = RESP_DECERR;
    end
`endif
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_fixed       <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          s_axi_rid     <= s_axi_arid;
          r_addr        <= s_axi_araddr;
          r_len         <= s_axi_arlen;
          r_fixed       <= (s_axi_arburst == 2'b00);
          r_cnt         <= '0;
          s_axi_arready <= 1'b0;
          s_axi_rvalid  <= 1'b1;
          s_axi_rdata   <= r_fetch_data;
          s_axi_rresp   <= r_fetch_resp;
          s_axi_rlast   <= (s_axi_arlen == 8'd0);
          r_state       <= R_DATA;
        end
        R_DATA: if (s_axi_rready) begin
          if (s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end else begin
            r_addr      <= r_fetch_addr;
            r_cnt       <= r_cnt + 9'd1;
            s_axi_rdata <= r_fetch_data;
            s_axi_rresp <= r_fetch_resp;
            s_axi_rlast <= ((r_cnt + 9'd1) == {1'b0, r_len});
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave: bursts, strobes, FIXED/INCR, back-pressure,
// wlast mismatch, 256-beat bursts, mid-burst reset and address aliasing / decode errors.
`timescale 1ns/1ps
module tb_axi_mem_slave;
  localparam int ID_W = 4;

  logic              s_axi_aclk = 1'b0;
  logic              s_axi_aresetn = 1'b0;
  logic [ID_W-1:0]   s_axi_awid = '0;
  logic [31:0]       s_axi_awaddr = '0;
  logic [7:0]        s_axi_awlen = '0;
  logic [1:0]        s_axi_awburst = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata = '0;
  logic [3:0]        s_axi_wstrb = '0;
  logic              s_axi_wlast = 1'b0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b1;
  logic [ID_W-1:0]   s_axi_arid = '0;
  logic [31:0]       s_axi_araddr = '0;
  logic [7:0]        s_axi_arlen = '0;
  logic [1:0]        s_axi_arburst = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;

  axi_mem_slave dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [1:0]  exp_rresp = 2'b00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic fill_exp(input logic [31:0] d0, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(d0 + 32'(i));
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input logic [3:0] strb,
                           input logic [31:0] d0, input logic [1:0] exp_bresp);
    int n;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    check("aw_handshake", 32'(n < 50), 32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_axi_wdata = d0 + 32'(i); s_axi_wstrb = strb;
      s_axi_wlast = (i == nbeats - 1); s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin tick(); n++; end
      check("w_handshake", 32'(n < 50), 32'd1);
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("bvalid", 32'(s_axi_bvalid), 32'd1);
    check("bid", 32'(s_axi_bid), 32'(id));
    check("bresp", 32'(s_axi_bresp), 32'(exp_bresp));
    tick();
    check("bvalid_clr", 32'(s_axi_bvalid), 32'd0);
    check("awready_back", 32'(s_axi_awready), 32'd1);
  endtask

  // pat bit i drives rready in cycle i of the data phase (repeating every plen cycles).
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [15:0] pat, input int plen,
                          input int exp_cycles);
    int n, beat, cyc;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    check("ar_handshake", 32'(n < 50), 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
    check("rvalid_first", 32'(s_axi_rvalid), 32'd1);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 2000) begin
      s_axi_rready = pat[cyc % plen];
      check("rvalid", 32'(s_axi_rvalid), 32'd1);
      check("rdata", s_axi_rdata, exp_q[beat]);
      check("rlast", 32'(s_axi_rlast), 32'(beat == int'(len)));
      check("rid", 32'(s_axi_rid), 32'(id));
      check("rresp", 32'(s_axi_rresp), 32'(exp_rresp));
      tick();
      if (s_axi_rready) beat++;
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", 32'(beat), 32'(int'(len) + 1));
    check("r_cycles", 32'(cyc), 32'(exp_cycles));
    check("rvalid_end", 32'(s_axi_rvalid), 32'd0);
    check("arready_end", 32'(s_axi_arready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge s_axi_aclk);
    #1;
    check("rst_awready", 32'(s_axi_awready), 32'd1);
    check("rst_arready", 32'(s_axi_arready), 32'd1);
    check("rst_wready",  32'(s_axi_wready),  32'd0);
    check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    check("rst_bresp",   32'(s_axi_bresp),   32'd0);
    check("rst_rresp",   32'(s_axi_rresp),   32'd0);
    check("rst_rdata",   s_axi_rdata,        32'd0);
    check("rst_rlast",   32'(s_axi_rlast),   32'd0);
    check("rst_ids",     32'({s_axi_bid, s_axi_rid}), 32'd0);
    s_axi_aresetn = 1'b1;
    tick();

    // Single-beat write then read back
    axi_write(4'd1, 32'h10, 8'd0, 2'b01, 1, 4'hF, 32'hDEADBEEF, 2'b00);
    fill_exp(32'hDEADBEEF, 1);
    axi_read(4'd1, 32'h10, 8'd0, 2'b01, 16'hFFFF, 1, 1);

    // 4-beat INCR, streamed read at one beat per cycle
    axi_write(4'd2, 32'h100, 8'd3, 2'b01, 4, 4'hF, 32'd1, 2'b00);
    fill_exp(32'd1, 4);
    axi_read(4'd2, 32'h100, 8'd3, 2'b01, 16'hFFFF, 1, 4);

    // Back-pressure 1,0,0,1,1,0,1
    axi_read(4'd5, 32'h100, 8'd3, 2'b01, 16'h0059, 7, 7);

    // Byte strobes merge into existing word
    axi_write(4'd3, 32'h40, 8'd0, 2'b01, 1, 4'hF, 32'h11223344, 2'b00);
    axi_write(4'd3, 32'h40, 8'd0, 2'b01, 1, 4'b0101, 32'hAABBCCDD, 2'b00);
    fill_exp(32'h11BB33DD, 1);
    axi_read(4'd3, 32'h40, 8'd0, 2'b01, 16'hFFFF, 1, 1);

    // FIXED burst leaves only the final beat; FIXED read repeats it
    axi_write(4'd4, 32'h20, 8'd2, 2'b00, 3, 4'hF, 32'hA0, 2'b00);
    exp_q.delete(); repeat (3) exp_q.push_back(32'hA2);
    axi_read(4'd4, 32'h20, 8'd2, 2'b00, 16'hFFFF, 1, 3);

    // Early wlast -> SLVERR; following burst OKAY
    axi_write(4'd6, 32'h200, 8'd3, 2'b01, 2, 4'hF, 32'h300, 2'b10);
    axi_write(4'd6, 32'h200, 8'd1, 2'b01, 2, 4'hF, 32'h400, 2'b00);
    fill_exp(32'h400, 2);
    axi_read(4'd6, 32'h200, 8'd1, 2'b01, 16'hFFFF, 1, 2);

    // 256-beat bursts (len=255)
    axi_write(4'd7, 32'h800, 8'd255, 2'b01, 256, 4'hF, 32'h1000, 2'b00);
    fill_exp(32'h1000, 256);
    axi_read(4'd7, 32'h800, 8'd255, 2'b01, 16'hFFFF, 1, 256);

`ifdef AXI_MEM_BOUNDS_CHECK_EN
    axi_write(4'd8, 32'h1000, 8'd0, 2'b01, 1, 4'hF, 32'h55, 2'b11);
    exp_rresp = 2'b11;
    fill_exp(32'd0, 1);
    axi_read(4'd8, 32'h1000, 8'd0, 2'b01, 16'hFFFF, 1, 1);
    exp_rresp = 2'b00;
`else
    // Aliasing modulo DEPTH and INCR wrap from the top word to word 0
    fill_exp(32'hDEADBEEF, 1);
    axi_read(4'd8, 32'h1010, 8'd0, 2'b01, 16'hFFFF, 1, 1);
    axi_write(4'd9, 32'hFFC, 8'd1, 2'b01, 2, 4'hF, 32'h5000, 2'b00);
    fill_exp(32'h5000, 2);
    axi_read(4'd9, 32'hFFC, 8'd1, 2'b01, 16'hFFFF, 1, 2);
`endif

    // Reset during beat 2 of an 8-beat read
    s_axi_arid = 4'd2; s_axi_araddr = 32'h800; s_axi_arlen = 8'd7; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    tick();
    tick();
    s_axi_rready = 1'b0;
    check("mid_rdata", s_axi_rdata, 32'h1002);
    check("mid_rvalid", 32'(s_axi_rvalid), 32'd1);
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    check("async_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("async_arready", 32'(s_axi_arready), 32'd1);
    tick();
    tick();
    s_axi_aresetn = 1'b1;
    tick();
    check("post_rst_arready", 32'(s_axi_arready), 32'd1);
    check("post_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    fill_exp(32'd1, 1);
    axi_read(4'd1, 32'h100, 8'd0, 2'b01, 16'hFFFF, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
